// File: rtl/uart_rx_ctrl.sv
// UART receive framing controller: synchronises rxd, times mid-bit sampling and strobes the downstream shifter.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic shift_en,
    output logic shift_data,
    output logic frame_valid,
    output logic frame_err,
`ifdef UART_RX_PARITY_EN
    output logic busy,
    output logic parity_err
`else
    output logic busy
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_clks_per_bit
        $error("uart_rx_ctrl: CLKS_PER_BIT must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
        $error("uart_rx_ctrl: DATA_BITS must be in 5..8");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_rx_ctrl: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] data_idx_q, data_idx_d;
    logic             rxd_meta_q;
    logic             rxd_s_q;
    logic             shift_en_q, shift_en_d;
    logic             shift_data_q, shift_data_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             par_fail_q, par_fail_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic tick_half;
    logic tick_full;

    assign tick_half = (bit_cnt_q == HALF_LAST);
    assign tick_full = (bit_cnt_q == FULL_LAST);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        data_idx_d    = data_idx_q;
        shift_en_d    = 1'b0;
        shift_data_d  = shift_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d         = par_q;
        par_fail_d    = par_fail_q;
        parity_err_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                bit_cnt_d  = '0;
                data_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                // Seeding with the sense bit turns the data XOR into the expected parity bit.
                par_d      = (PARITY_ODD != 0);
                par_fail_d = 1'b0;
`endif
                if (!rxd_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_half) begin
                    bit_cnt_d = '0;
                    state_d   = rxd_s_q ? S_IDLE : S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tick_full) begin
                    bit_cnt_d    = '0;
                    shift_en_d   = 1'b1;
                    shift_data_d = rxd_s_q;
                    data_idx_d   = data_idx_q + IDX_W'(1);
`ifdef UART_RX_PARITY_EN
                    par_d        = par_q ^ rxd_s_q;
                    if (data_idx_q == IDX_LAST) begin
                        state_d = S_PARITY;
                    end
`else
                    if (data_idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_full) begin
                    bit_cnt_d  = '0;
                    par_fail_d = (rxd_s_q != par_q);
                    state_d    = S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (tick_full) begin
                    bit_cnt_d = '0;
                    if (rxd_s_q) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_d  = par_fail_q;
                        frame_valid_d = !par_fail_q;
`else
                        frame_valid_d = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BRK_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_BRK_WAIT: begin
                // A held-low line must go idle before another start bit is believed.
                bit_cnt_d = '0;
                if (rxd_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q    <= 1'b1;
            rxd_s_q       <= 1'b1;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            data_idx_q    <= '0;
            shift_en_q    <= 1'b0;
            shift_data_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q         <= 1'b0;
            par_fail_q    <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rxd_meta_q    <= rxd;
            rxd_s_q       <= rxd_meta_q;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            data_idx_q    <= data_idx_d;
            shift_en_q    <= shift_en_d;
            shift_data_q  <= shift_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q         <= par_d;
            par_fail_q    <= par_fail_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign shift_en    = shift_en_q;
    assign shift_data  = shift_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven frames, directed corner sequences and random frames
// checked against an event-level model (expected bytes and strobe counts per frame).
module tb_uart_rx_ctrl;
    localparam int CPB        = 16;
    localparam int DB         = 8;
    localparam int PARITY_ODD = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic shift_en, shift_data, frame_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
`else
    logic parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PARITY_ODD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .shift_en    (shift_en),
        .shift_data  (shift_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
        .busy        (busy),
        .parity_err  (parity_err)
`else
        .busy        (busy)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Observed events since the last clear
    logic shift_bits[$];
    int   shift_t[$];
    int   n_valid, n_err, n_perr, n_busy, last_valid_t, overlap_bad;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (shift_en) begin
                shift_bits.push_back(shift_data);
                shift_t.push_back(cyc);
            end
            if (frame_valid) begin
                n_valid++;
                last_valid_t = cyc;
            end
            if (frame_err)  n_err++;
            if (parity_err) n_perr++;
            if (busy)       n_busy++;
            if ((shift_en && (frame_valid || frame_err)) || (frame_valid && frame_err) ||
                (parity_err && (frame_valid || frame_err)))
                overlap_bad++;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic clear_obs();
        shift_bits.delete();
        shift_t.delete();
        n_valid = 0; n_err = 0; n_perr = 0; n_busy = 0; last_valid_t = 0; overlap_bad = 0;
    endtask

    task automatic send_bit(input logic b, input int ncyc);
        rxd = b;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0, CPB);
        for (int i = 0; i < DB; i++) send_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ 1'(PARITY_ODD) ^ par_flip, CPB);
`else
        if (par_flip) begin end
`endif
        send_bit(stop, CPB);
    endtask

    function automatic logic [7:0] byte_at(input int base);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < DB; i++)
            if (base + i < shift_bits.size()) b[i] = shift_bits[base + i];
        return b;
    endfunction

    task automatic check_frame(input string name, input logic [7:0] exp_byte,
                               input int exp_valid, input int exp_err, input int exp_perr);
        int bad = 0;
        chk({name, "_nshift"}, shift_bits.size(), DB);
        chk({name, "_byte"}, int'(byte_at(0)), int'(exp_byte));
        chk({name, "_valid"}, n_valid, exp_valid);
        chk({name, "_ferr"}, n_err, exp_err);
        chk({name, "_perr"}, n_perr, exp_perr);
        for (int i = 1; i < shift_t.size(); i++)
            if (shift_t[i] - shift_t[i-1] != CPB) bad++;
        chk({name, "_spacing"}, bad, 0);
        if (n_valid > 0 && shift_t.size() > 0)
            chk({name, "_valid_gap"}, int'(last_valid_t - shift_t[shift_t.size()-1] >= CPB), 1);
        chk({name, "_overlap"}, overlap_bad, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic [7:0] exp_byte;
        int         exp_valid;
        int         exp_err;
        int         exp_perr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] d;
        logic       stop, flip;
        int         gap, ev, ee, ep;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1, 0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 0, 1, 0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1, 0, 0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1, 0, 0};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h81, 0, 1, 0};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1, 0, 0};
`ifdef UART_RX_PARITY_EN
        vecs[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0, 0, 1};
`else
        vecs[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1, 0, 0};
`endif
        clear_obs();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_shift_en", shift_en, 0);
        chk("rst_shift_data", shift_data, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        send_bit(1'b1, 2 * CPB);

        // Table-driven frames
        foreach (vecs[k]) begin
            clear_obs();
            send_frame(vecs[k].data, vecs[k].par_flip, vecs[k].stop);
            send_bit(1'b1, 2 * CPB);
            check_frame($sformatf("vec%0d", k), vecs[k].exp_byte,
                        vecs[k].exp_valid, vecs[k].exp_err, vecs[k].exp_perr);
            chk($sformatf("vec%0d_busy_after", k), busy, 0);
            $display("vec%0d data=%02h stop=%0b shifts=%0d valid=%0d ferr=%0d perr=%0d",
                     k, vecs[k].data, vecs[k].stop, shift_bits.size(), n_valid, n_err, n_perr);
        end

        // Short glitch on the line: no strobes, brief busy
        clear_obs();
        send_bit(1'b0, 4);
        send_bit(1'b1, 2 * CPB);
        chk("glitch_nshift", shift_bits.size(), 0);
        chk("glitch_strobes", n_valid + n_err + n_perr, 0);
        chk("glitch_busy_len", int'(n_busy >= 6 && n_busy <= 10), 1);
        chk("glitch_busy_after", busy, 0);
        $display("glitch busy_cycles=%0d", n_busy);

        // Bad stop bit followed by a held break, then a clean frame
        clear_obs();
        send_frame(8'h3C, 1'b0, 1'b0);
        check_frame("brk_frame", 8'h3C, 0, 1, 0);
        clear_obs();
        send_bit(1'b0, 40);
        chk("brk_hold_nshift", shift_bits.size(), 0);
        chk("brk_hold_strobes", n_valid + n_err, 0);
        chk("brk_hold_busy", busy, 1);
        send_bit(1'b1, 2 * CPB);
        chk("brk_release_busy", busy, 0);
        clear_obs();
        send_frame(8'h3C, 1'b0, 1'b1);
        send_bit(1'b1, CPB);
        check_frame("brk_clean", 8'h3C, 1, 0, 0);
        $display("break sequence done valid=%0d ferr=%0d", n_valid, n_err);

        // Reset after the third shift of a frame
        clear_obs();
        d = 8'h81;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 3; i++) send_bit(d[i], CPB);
        chk("midrst_pre_nshift", shift_bits.size(), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_shift_en", shift_en, 0);
        chk("midrst_shift_data", shift_data, 0);
        chk("midrst_frame_valid", frame_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        send_bit(1'b1, 12 * CPB);
        chk("midrst_post_nshift", shift_bits.size(), 3);
        chk("midrst_post_strobes", n_valid + n_err + n_perr, 0);
        clear_obs();
        send_frame(8'h81, 1'b0, 1'b1);
        send_bit(1'b1, CPB);
        check_frame("midrst_next", 8'h81, 1, 0, 0);
        $display("midframe reset sequence done");

        // Back-to-back frames with a single stop bit
        clear_obs();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_bit(1'b1, CPB);
        chk("b2b_nshift", shift_bits.size(), 2 * DB);
        chk("b2b_byte0", int'(byte_at(0)), 8'h00);
        chk("b2b_byte1", int'(byte_at(DB)), 8'hFF);
        chk("b2b_valid", n_valid, 2);
        chk("b2b_ferr", n_err, 0);
        chk("b2b_overlap", overlap_bad, 0);
        $display("back-to-back shifts=%0d valid=%0d", shift_bits.size(), n_valid);

        // Random frames against the event-level model
        for (int r = 0; r < 40; r++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            flip = 1'($urandom_range(0, 1));
`else
            flip = 1'b0;
`endif
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            ev   = (stop && !flip) ? 1 : 0;
            ee   = stop ? 0 : 1;
            ep   = (stop && flip) ? 1 : 0;
            clear_obs();
            send_frame(d, flip, stop);
            check_frame($sformatf("rnd%0d", r), d, ev, ee, ep);
            $display("rnd%0d data=%02h stop=%0b flip=%0b got=%02h valid=%0d ferr=%0d perr=%0d",
                     r, d, stop, flip, byte_at(0), n_valid, n_err, n_perr);
            if (gap > 0) send_bit(1'b1, gap * CPB);
        end
        send_bit(1'b1, 2 * CPB);
        chk("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
